led_scan_controller: RTL

//  Time-multiplexed column scanner for the N x N LED matrix. It sequences the column index and

---
 rtl/led_pkg.sv | 25 ++
 rtl/led_scan_controller_if.sv | 34 +++
 rtl/tick_counter.sv | 49 ++++
 rtl/led_scan_controller.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : led_pkg                                                          |
// | Purpose : Shared types and constants for the LED matrix column scanner.    |
// |           scan_state_t - two-phase column state (dark / lit)               |
// |           N_MAX        - largest supported grid dimension                  |
// |           cnt_width()  - bits needed to count 0..max                       |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package led_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } scan_state_t;

  localparam int N_MAX = 8;

  // Width of a counter that must be able to hold the value max.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_scan_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : led_scan_controller_if                                           |
// | Purpose : Frame handshake between the cell update logic (master) and the   |
// |           column scanner (slave).                                          |
// |   cells_in     N*N  next frame, row-major, bit r*N+c = row r column c      |
// |   cells_valid  1    cells_in holds a frame to load                         |
// |   cells_ready  1    scanner can accept a frame this cycle                  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface led_scan_controller_if
  import led_pkg::*;
#(
  parameter int N = 8
) ();

  logic [N*N-1:0] cells_in;
  logic           cells_valid;
  logic           cells_ready;

  modport master (
    output cells_in,
    output cells_valid,
    input  cells_ready
  );

  modport slave (
    input  cells_in,
    input  cells_valid,
    output cells_ready
  );

endinterface
`default_nettype wire

// File: rtl/tick_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tick_counter                                                     |
// | Purpose : Free-wrapping phase counter 0..MAX-1.                            |
// |   clk   in   system clock                                                  |
// |   rst   in   synchronous active-high reset                                 |
// |   clr   in   force count back to 0 (wins over en)                          |
// |   en    in   advance one tick                                              |
// |   last  out  count is at MAX-1 (final tick of the phase)                   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tick_counter
  import led_pkg::*;
#(
  parameter int MAX = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic en,
  output logic      last
);

  localparam int CW = cnt_width(MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    last  = (cnt_q == CW'(MAX - 1));
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      // Wrap on its own so the counter is already 0 when its phase comes round again.
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : led_scan_controller                                              |
// | Purpose : Time-multiplexed column scanner for an N x N LED matrix with     |
// |           inter-column blanking and a double-buffered frame image.         |
// |   clk          in   system clock                                           |
// |   rst          in   synchronous active-high reset                          |
// |   run          in   1 = scan, 0 = hold dark                                |
// |   frame_if     slv  cells_in / cells_valid / cells_ready handshake         |
// |   x            out  column index 0..N-1 to the driver decoder             |
// |   ena          out  decoder enable, high only in the lit phase            |
// |   cells        out  frame currently displayed                             |
// |   frame_start  out  one-cycle pulse as column 0 of a frame begins         |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module led_scan_controller
  import led_pkg::*;
#(
  parameter int N           = 8,
  parameter int ON_TICKS    = 1000,
  parameter int BLANK_TICKS = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             run,
  led_scan_controller_if.slave  frame_if,
  output logic [$clog2(N):0]    x,
  output logic                  ena,
  output logic [N*N-1:0]        cells,
  output logic                  frame_start
);

  localparam int XW = $clog2(N) + 1;

  // Elaboration-time parameter guards.
  if (N < 1 || N > N_MAX) begin : g_bad_n
    $error("led_scan_controller: N=%0d outside 1..%0d", N, N_MAX);
  end
  if (ON_TICKS < 1) begin : g_bad_on
    $error("led_scan_controller: ON_TICKS must be >= 1");
  end
  if (BLANK_TICKS < 1) begin : g_bad_blank
    $error("led_scan_controller: BLANK_TICKS must be >= 1");
  end

  scan_state_t    state_q, state_d;
  logic           started_q, started_d;
  logic [XW-1:0]  x_q, x_d;
  logic           ena_q, ena_d;
  logic           fs_q, fs_d;
  logic [N*N-1:0] cells_q, cells_d;
  logic [N*N-1:0] pending_q, pending_d;
  logic           pending_full_q, pending_full_d;

  logic           scanning;
  logic           blank_last;
  logic           on_last;
  logic           frame_boundary;
  logic           accept;

  // started_q marks that the first column-0 blanking cycle after a
  // (re)start has been issued; counters only run once it is set.
  assign scanning = run && started_q;

  tick_counter #(.MAX(BLANK_TICKS)) u_blank_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (!scanning),
    .en   (scanning && (state_q == S_BLANK)),
    .last (blank_last)
  );

  tick_counter #(.MAX(ON_TICKS)) u_on_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (!scanning),
    .en   (scanning && (state_q == S_ON)),
    .last (on_last)
  );

  assign accept               = frame_if.cells_valid && !pending_full_q;
  assign frame_if.cells_ready = !pending_full_q;

  always_comb begin
    state_d        = state_q;
    started_d      = started_q;
    x_d            = x_q;
    fs_d           = 1'b0;
    frame_boundary = 1'b0;
    cells_d        = cells_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;

    if (!run) begin
      // Stopping parks the scan at column 0 and counts as a frame boundary.
      state_d        = S_BLANK;
      started_d      = 1'b0;
      x_d            = '0;
      frame_boundary = 1'b1;
    end else if (!started_q) begin
      state_d   = S_BLANK;
      started_d = 1'b1;
      x_d       = '0;
      fs_d      = 1'b1;
    end else begin
      case (state_q)
        S_BLANK: begin
          if (blank_last) begin
            state_d = S_ON;
          end
        end
        S_ON: begin
          if (on_last) begin
            state_d = S_BLANK;
            // x only moves as the lit phase ends, so it is stable while ena is high.
            if (x_q == XW'(N - 1)) begin
              x_d            = '0;
              fs_d           = 1'b1;
              frame_boundary = 1'b1;
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
        default: state_d = S_BLANK;
      endcase
    end

    ena_d = (state_d == S_ON);

    // Swap and accept are mutually exclusive: accept needs pending empty,
    // swap needs it full.
    if (frame_boundary && pending_full_q) begin
      cells_d        = pending_q;
      pending_full_d = 1'b0;
    end
    if (accept) begin
      pending_d      = frame_if.cells_in;
      pending_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_BLANK;
      started_q      <= 1'b0;
      x_q            <= '0;
      ena_q          <= 1'b0;
      fs_q           <= 1'b0;
      cells_q        <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      started_q      <= started_d;
      x_q            <= x_d;
      ena_q          <= ena_d;
      fs_q           <= fs_d;
      cells_q        <= cells_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
    end
  end

  assign x           = x_q;
  assign ena         = ena_q;
  assign cells       = cells_q;
  assign frame_start = fs_q;

endmodule
`default_nettype wire
